// File: rtl/block_checker.sv
// block_checker: streaming begin/end keyword-balance monitor for 8-bit ASCII.
//
// Ports:
//   clk    - rising-edge clock; one character sampled per edge
//   reset  - asynchronous, active-high; clears FSM, depth and err
//   in     - ASCII character; 0x20 is the only word delimiter
//   result - 1 while depth is zero and no unmatched `end` has been confirmed
//
// Configuration macro: BLOCK_CHECKER_STICKY_ERR_EN
//   defined   : sticky err latch; a confirmed unmatched `end` holds result low
//               until reset.
//   undefined : no err latch; result = (depth == 0), depth may go negative.
module block_checker (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  output logic       result
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_B,
    S_BE,
    S_BEG,
    S_BEGI,
    S_BEGIN,
    S_E,
    S_EN,
    S_END,
    S_OTHER
  } state_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_D     = 8'h64;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6e;

  state_t             state_q, state_d;
  logic signed [31:0] depth_q, depth_d;
  logic [7:0]         lc;
  logic               is_space;

  // Folding bit 5 lowercases letters. 0x00 folds to 0x20, so the space test
  // must use the raw byte, never the folded one.
  assign lc       = in | 8'h20;
  assign is_space = (in == CH_SPACE);

`ifdef BLOCK_CHECKER_STICKY_ERR_EN
  logic err_q, err_d;
`endif

  // Depth is updated tentatively on the last letter of a keyword; a following
  // space confirms it, any other character undoes it.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
`ifdef BLOCK_CHECKER_STICKY_ERR_EN
    err_d   = err_q;
`endif
    if (is_space) begin
      state_d = S_IDLE;
`ifdef BLOCK_CHECKER_STICKY_ERR_EN
      // depth_q already carries the tentative decrement of this `end`.
      if (state_q == S_END && depth_q < 0) begin
        err_d = 1'b1;
      end
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lc == CH_B)      state_d = S_B;
          else if (lc == CH_E) state_d = S_E;
          else                 state_d = S_OTHER;
        end
        S_B:    state_d = (lc == CH_E) ? S_BE   : S_OTHER;
        S_BE:   state_d = (lc == CH_G) ? S_BEG  : S_OTHER;
        S_BEG:  state_d = (lc == CH_I) ? S_BEGI : S_OTHER;
        S_BEGI: begin
          if (lc == CH_N) begin
            state_d = S_BEGIN;
            depth_d = depth_q + 32'sd1;
          end else begin
            state_d = S_OTHER;
          end
        end
        S_BEGIN: begin
          state_d = S_OTHER;
          depth_d = depth_q - 32'sd1;
        end
        S_E:    state_d = (lc == CH_N) ? S_EN : S_OTHER;
        S_EN: begin
          if (lc == CH_D) begin
            state_d = S_END;
            depth_d = depth_q - 32'sd1;
          end else begin
            state_d = S_OTHER;
          end
        end
        S_END: begin
          state_d = S_OTHER;
          depth_d = depth_q + 32'sd1;
        end
        default: state_d = S_OTHER;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      depth_q <= '0;
`ifdef BLOCK_CHECKER_STICKY_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
`ifdef BLOCK_CHECKER_STICKY_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

`ifdef BLOCK_CHECKER_STICKY_ERR_EN
  assign result = (depth_q == '0) && !err_q;
`else
  assign result = (depth_q == '0);
`endif

endmodule

// File: tb/tb_block_checker.sv
// tb_block_checker: directed test-plan sequences plus random word streams for
// block_checker, compared every cycle against a word-level reference model.
module tb_block_checker;

  logic       clk;
  logic       reset;
  logic [7:0] in;
  logic       result;

  int n_tests = 0;
  int n_fail  = 0;

  block_checker dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: committed depth, sticky error, lowercased current word.
  int  m_depth;
  bit  m_err;
  byte m_word[$];

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit word_is(input string k);
    if (m_word.size() != k.len()) return 1'b0;
    for (int i = 0; i < k.len(); i++)
      if (m_word[i] != k[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Contribution of the word typed so far, as if a space followed it now.
  function automatic int pending();
    if (word_is("begin")) return 1;
    if (word_is("end"))   return -1;
    return 0;
  endfunction

  function automatic bit model_result();
`ifdef BLOCK_CHECKER_STICKY_ERR_EN
    return ((m_depth + pending()) == 0) && !m_err;
`else
    return (m_depth + pending()) == 0;
`endif
  endfunction

  function automatic void model_reset();
    m_depth = 0;
    m_err   = 1'b0;
    m_word.delete();
  endfunction

  function automatic void model_step(input byte c);
    if (c == 8'h20) begin
      m_depth += pending();
      if (word_is("end") && m_depth < 0) m_err = 1'b1;
      m_word.delete();
    end else if (m_word.size() < 8) begin
      // A 0x00 folds to 0x20 here; it can never match a keyword letter.
      m_word.push_back(c | 8'h20);
    end
  endfunction

  task automatic send(input byte c);
    in = c;
    @(posedge clk);
    #1;
    model_step(c);
    check("result", result, model_result());
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_async", result, 1'b1);
    @(posedge clk);
    #1;
    check("reset_hold", result, 1'b1);
    reset = 1'b0;
  endtask

  string words[12] = '{"begin", "end", "BeGiN", "End", "beginx", "en",
                       "bx", "endd", "x", "ENDbegin", "beGIN", "eNd"};

  initial begin
    reset = 1'b1;
    in    = 8'h20;
    model_reset();
    #1;
    check("reset_initial", result, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle on spaces.
    for (int i = 0; i < 4; i++) send(8'h20);

    // beginbEGin : drops after n, returns after b.
    send_str("begin");
    check("begin_n", result, 1'b0);
    send("b");
    check("undo_b", result, 1'b1);
    send_str("EGin  ");
    check("beginbEGin_end", result, 1'b1);

    // bEgIN ENdenD End
    send_str("bEgIN");
    check("bEgIN", result, 1'b0);
    send_str(" ENdenD");
    check("ENdenD", result, 1'b0);
    send_str(" End");
    check("End_d", result, 1'b1);
    send(8'h20);

    // Nested.
    send_str("begin ");
    check("nest1", result, 1'b0);
    send_str("begin ");
    check("nest2", result, 1'b0);
    send_str("end ");
    check("nest3", result, 1'b0);
    send_str("end ");
    check("nest4", result, 1'b1);

    // 0x00 is a non-letter character.
    send(8'h00);
    send_str("begin ");
    check("nul_word", result, 1'b1);

    // Unmatched end, then begin.
    send_str("end");
    check("unmatched_d", result, 1'b0);
    send(8'h20);
    send_str("begin ");
`ifdef BLOCK_CHECKER_STICKY_ERR_EN
    check("sticky_err", result, 1'b0);
`else
    check("no_sticky", result, 1'b1);
`endif

    // Reset mid-word after "begi".
    do_reset();
    send_str("begi");
    do_reset();
    send("n");
    check("after_reset_n", result, 1'b1);
    send(8'h20);
    check("after_reset_sp", result, 1'b1);

    // Random word streams with occasional stray bytes and resets.
    for (int blk = 0; blk < 40; blk++) begin
      for (int w = 0; w < 12; w++) begin
        if ($urandom_range(0, 9) == 0) begin
          send(byte'($urandom_range(0, 255)));
        end else begin
          send_str(words[$urandom_range(0, 11)]);
        end
        if ($urandom_range(0, 7) != 0) send(8'h20);
        if ($urandom_range(0, 30) == 0) do_reset();
      end
      if ($urandom_range(0, 2) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
